// File: rtl/spi_master_gen.sv
// Register-access SPI master: ID, address and data fields shifted MSB first in any CPOL/CPHA mode.
// Define SPI_MASTER_LOOPBACK_EN to sample the module's own mosi and load rdata on every frame.
module spi_master_gen #(
  parameter int ID_W = 8,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int NUM_SS = 1,
  parameter logic [ID_W-1:0] SLAVE_IDW = ID_W'(8'hff),
  parameter logic [ID_W-1:0] SLAVE_IDR = ID_W'(8'h00),
  parameter int HOLD_CYC = 16,
  localparam int SS_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic [9:0]        half_period,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              start_wr,
  input  logic              start_re,
  input  logic              miso,
  output logic [NUM_SS-1:0] ss_n,
  output logic              sclk,
  output logic              mosi,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done
);

  localparam int FRAME_W = ID_W + ADDR_W + DATA_W;
  localparam int HDR_W   = ID_W + ADDR_W;
  localparam int EDGES   = 2 * FRAME_W;
  localparam int EC_W    = $clog2(EDGES + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

  state_t              r_state;
  logic [1:0]          r_wr_sync;
  logic [1:0]          r_re_sync;
  logic [NUM_SS-1:0]   r_ss_n;
  logic                r_sclk;
  logic                r_mosi;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_busy;
  logic                r_done;
  logic [9:0]          r_cnt;
  logic [9:0]          r_hp;
  logic [EC_W-1:0]     r_edge_cnt;
  logic [FRAME_W-1:0]  r_tx;
  logic [DATA_W-1:0]   r_rx;
  logic                r_cpha;
  logic                r_rw;

  logic                w_wr_edge;
  logic                w_re_edge;
  logic                w_start;
  logic [FRAME_W-1:0]  w_frame;
  logic [NUM_SS-1:0]   w_ss_dec;
  logic                w_miso;
  logic                w_tick;
  logic                w_sample;
  logic                w_in_data;
  logic                w_last_edge;
  logic                w_hold_end;
  logic                w_load_rdata;
  logic [DATA_W-1:0]   w_rx_next;

  assign w_wr_edge = r_wr_sync[0] & ~r_wr_sync[1];
  assign w_re_edge = r_re_sync[0] & ~r_re_sync[1];
  assign w_start   = w_wr_edge | w_re_edge;

  // Read wins when both requests arrive together.
  assign w_frame = w_re_edge ? {SLAVE_IDR, addr, {DATA_W{1'b0}}}
                             : {SLAVE_IDW, addr, wdata};

  // Out-of-range ss_sel decodes to no select at all.
  for (genvar gi = 0; gi < NUM_SS; gi++) begin : g_ss_dec
    assign w_ss_dec[gi] = (ss_sel == SS_W'(gi));
  end

`ifdef SPI_MASTER_LOOPBACK_EN
  assign w_miso       = r_mosi;
  assign w_load_rdata = 1'b1;
`else
  assign w_miso       = miso;
  assign w_load_rdata = r_rw;
`endif

  assign w_tick      = (r_cnt == r_hp);
  // Edge parity against cpha selects sample vs launch; bit index is edges-so-far / 2.
  assign w_sample    = (r_edge_cnt[0] == r_cpha);
  assign w_in_data   = ((r_edge_cnt >> 1) >= EC_W'(HDR_W));
  assign w_last_edge = (r_edge_cnt == EC_W'(EDGES - 1));
  assign w_hold_end  = (r_cnt == 10'(HOLD_CYC - 1));
  assign w_rx_next   = DATA_W'({r_rx, w_miso});

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state    <= S_IDLE;
      r_wr_sync  <= '0;
      r_re_sync  <= '0;
      r_ss_n     <= '1;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_rdata    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cnt      <= '0;
      r_hp       <= '0;
      r_edge_cnt <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_cpha     <= 1'b0;
      r_rw       <= 1'b0;
    end else begin
      r_wr_sync <= {r_wr_sync[0], start_wr};
      r_re_sync <= {r_re_sync[0], start_re};
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_rw       <= w_re_edge;
            r_hp       <= half_period;
            r_cpha     <= cpha;
            r_sclk     <= cpol;
            r_ss_n     <= ~w_ss_dec;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_cnt      <= '0;
            r_edge_cnt <= '0;
            r_rx       <= '0;
            r_state    <= S_SETUP;
            if (cpha) begin
              r_tx   <= w_frame;
              r_mosi <= 1'b0;
            end else begin
              r_tx   <= w_frame << 1;
              r_mosi <= w_frame[FRAME_W-1];
            end
          end
        end
        // The first sclk edge closes SETUP; the rest are paced identically in SHIFT.
        S_SETUP, S_SHIFT: begin
          if (w_tick) begin
            r_cnt      <= '0;
            r_sclk     <= ~r_sclk;
            r_edge_cnt <= r_edge_cnt + 1'b1;
            r_state    <= S_SHIFT;
            if (w_sample) begin
              if (w_in_data) r_rx <= w_rx_next;
            end else begin
              r_mosi <= r_tx[FRAME_W-1];
              r_tx   <= r_tx << 1;
            end
            if (w_last_edge) begin
              r_mosi  <= 1'b0;
              r_state <= S_HOLD;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (w_hold_end) begin
            r_ss_n  <= '1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
            if (w_load_rdata) r_rdata <= r_rx;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // In IDLE the line follows the live cpol input; during a frame the captured level drives it.
  assign sclk  = (r_state == S_IDLE) ? cpol : r_sclk;
  assign ss_n  = r_ss_n;
  assign mosi  = r_mosi;
  assign rdata = r_rdata;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: doc/spi_master_gen.md
Name: spi_master_gen

Overview:
Parametrised successor SPI master for register access to slave devices.
- Frame format: ID field, address field, data field, all MSB first. Each field width is a parameter.
- Supports all four SPI modes (CPOL/CPHA) and one-hot selection among NUM_SS slaves.
- Provides busy/done status and updates read data only on read frames.
- Sits between the host register logic and the board-level SPI pins.

Parameters:
ID_W, 8, width of slave-ID field (1..16)
ADDR_W, 8, width of address field (1..16)
DATA_W, 8, width of data field (1..32)
NUM_SS, 1, number of slave-select outputs (1..8)
SLAVE_IDW, 8'hff, ID_W-bit ID sent on write frames
SLAVE_IDR, 8'h00, ID_W-bit ID sent on read frames
HOLD_CYC, 16, clocks between last sclk edge and ss release (2..255)

Ports:
clock  in  1  system clock, rising edge
n_reset  in  1  asynchronous active-low reset
half_period  in  10  sclk half-phase length = half_period+1 clocks
cpol  in  1  sclk idle level
cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
ss_sel  in  $clog2(NUM_SS) (min 1)  target slave index
addr  in  ADDR_W  register address
wdata  in  DATA_W  write data
start_wr  in  1  rising edge requests a write frame
start_re  in  1  rising edge requests a read frame
miso  in  1  serial data from slave
ss_n  out  NUM_SS  active-low slave selects
sclk  out  1  serial clock
mosi  out  1  serial data to slave
rdata  out  DATA_W  last read data
busy  out  1  high from accepted start until return to IDLE
done  out  1  completion flag (level)

Behaviour:
- Reset values: ss_n all 1, sclk=cpol input value, mosi=0, rdata=0, busy=0, done=0, state IDLE, all counters 0. Reset mid-frame aborts immediately with no partial rdata update.
- Start inputs: each passes through 2 flops; a rising edge is 1d & ~2d.
  - An edge is accepted only in IDLE.
  - If both edges occur in the same cycle, read wins.
  - Edges seen while not in IDLE are dropped.
- On accept, capture in one cycle: addr, wdata, ss_sel, half_period, cpol, cpha, rw. Then busy=1, done=0.
- Frame length: F = ID_W+ADDR_W+DATA_W bits, i.e. 2F sclk edges.
- States:
  - IDLE: on accept go to SETUP.
  - SETUP: ss_n[ss_sel]=0 on the first cycle. Lasts half_period+1 clocks. If cpha=0, the first bit is driven on mosi on the first SETUP cycle. Then go to SHIFT.
  - SHIFT: sclk toggles every half_period+1 clocks, 2F toggles total, ending at idle level cpol.
    - cpha=0: mosi changes on trailing edges; miso sampled on leading edges.
    - cpha=1: mosi changes on leading edges; miso sampled on trailing edges.
    - After the 2F-th edge, go to HOLD.
  - HOLD: mosi=0. Lasts HOLD_CYC clocks. On the last cycle, ss_n goes all 1, busy=0, done=1, and the state returns to IDLE.
- Bit order: ID (SLAVE_IDW on write, SLAVE_IDR on read), then addr, then data field (wdata on write, zeros on read).
- miso is shifted in during the data field only.
- rdata: loaded from the shift register on the HOLD exit cycle, and only for read frames. Write frames leave rdata unchanged.
- done: stays 1 until the next accepted start.
- Input changes during a frame have no effect (captured copies are used).
- ss_sel >= NUM_SS: frame runs, but no ss_n asserts.
- Minimum half_period=0 gives sclk = clock/2.

Optional Feature:
Macro SPI_MASTER_LOOPBACK_EN.
- Defined: the internal miso sample source is the module's own mosi. The external miso is ignored. A read frame returns zeros in rdata; a write frame shifts wdata through the capture path, and an extra debug rule applies: rdata is also loaded on write frames, so rdata==wdata after a write.
- Undefined: external miso is used and rdata updates only on read frames as specified above.

Test Plan:
1. Defaults, cpol=0, cpha=0, half_period=4, start_wr with addr=8'h3C, wdata=8'hA5 -> mosi shows FF,3C,A5 MSB first on 24 rising edges; each sclk half is 5 clocks; ss_n[0] low from SETUP until 16 clocks after the last edge; done=1; rdata stays 0.
2. start_re, addr=8'h10, slave drives 8'h5A on miso during the data field -> ID 00 sent, data field mosi=0, rdata=8'h5A at done; busy low on the same cycle done rises.
3. Repeat scenario 2 for modes (1,0), (0,1), (1,1) -> sclk idles at cpol; sample/launch edges follow cpha; rdata=8'h5A in every mode.
4. start_re and start_wr rise in the same cycle -> read frame (ID 00); a second start_wr pulse mid-frame is ignored and produces exactly one frame.
5. NUM_SS=4, ADDR_W=16, DATA_W=16, ss_sel=2 -> only ss_n[2] asserts; frame is 40 bits (80 edges).
6. Assert n_reset mid-SHIFT -> all outputs return to reset values the same cycle; rdata unchanged from its previous value of 0; the next start runs a full normal frame.
